// File: rtl/mode6_sub_ctrl_pkg.sv
// Shared types and constants for the mode-6 subtract sequencer and its output FIFO.
package mode6_sub_ctrl_pkg;
  localparam int DEF_DATAWIDTH = 16;
  localparam int DEF_NUM_LANES = 8;
  localparam int DEF_LEN_WIDTH = 10;
  localparam int BEAT_W        = DEF_NUM_LANES * DEF_DATAWIDTH;
  localparam int FIFO_DEPTH    = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_MAX = 3'd1,
    RUN      = 3'd2,
    DRAIN    = 3'd3,
    DONE     = 3'd4
  } state_t;
endpackage

// File: rtl/mode6_sub_skid_fifo.sv
// Two-entry beat FIFO that absorbs downstream backpressure; head is always on dout.
module mode6_sub_skid_fifo
  import mode6_sub_ctrl_pkg::*;
#(
  parameter int W = BEAT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);
  logic [W-1:0] mem [FIFO_DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign dout = mem[rd_ptr];
endmodule

// File: rtl/mode6_sub_ctrl.sv
// Mode-6 (a - max) subtract sequencer: latches the row max, streams beats through the
// subtract lanes into a 2-entry FIFO. Optional MODE6_SUB_STATUS_EN adds sticky row status.
// Handshake: a beat transfers on a cycle where out_valid && out_ready; out_valid never
// drops and out_data never changes until that transfer happens.
module mode6_sub_ctrl
  import mode6_sub_ctrl_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int LEN_WIDTH = DEF_LEN_WIDTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [LEN_WIDTH-1:0]           num_beats,
  input  logic [DATAWIDTH-1:0]           max_in,
  input  logic                           max_valid,
  output logic                           rd_en,
  output logic [LEN_WIDTH-1:0]           rd_addr,
  input  logic [NUM_LANES*DATAWIDTH-1:0] rd_data,
  output logic [NUM_LANES*DATAWIDTH-1:0] sub_a,
  output logic [DATAWIDTH-1:0]           sub_b,
  input  logic [NUM_LANES*DATAWIDTH-1:0] sub_z,
  output logic [NUM_LANES*DATAWIDTH-1:0] out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           busy,
  output logic                           done,
`ifdef MODE6_SUB_STATUS_EN
  input  logic [NUM_LANES*8-1:0]         sub_status,
  output logic [7:0]                     row_status,
`endif
  output logic [2:0]                     state_dbg
);
  state_t               state, state_nx;
  logic [DATAWIDTH-1:0] max_q;
  logic [LEN_WIDTH-1:0] num_q;
  logic [LEN_WIDTH-1:0] issued;
  logic                 rd_valid;
  logic                 pop;
  logic [1:0]           fifo_count;
  logic                 drain_clear;

  assign pop       = out_valid & out_ready;
  assign out_valid = (fifo_count != 2'd0);
  assign sub_a     = rd_data;
  assign sub_b     = max_q;
  assign rd_addr   = issued;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign state_dbg = state;

  // Count this cycle's pop as free space so a steady stream sustains one beat per cycle.
  assign rd_en = (state == RUN) && (issued != num_q) &&
                 (({1'b0, fifo_count} + {2'b00, rd_valid}) < (3'd2 + {2'b00, pop}));

  // Row is finished once nothing is in flight and the FIFO empties this cycle.
  assign drain_clear = !rd_valid &&
                       ((fifo_count == 2'd0) || (fifo_count == 2'd1 && pop));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (start) state_nx = WAIT_MAX;
      WAIT_MAX: if (max_valid) state_nx = (num_q == '0) ? DONE : RUN;
      RUN:      if (issued == num_q) state_nx = DRAIN;
      DRAIN:    if (drain_clear) state_nx = DONE;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      max_q    <= '0;
      num_q    <= '0;
      issued   <= '0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_nx;
      rd_valid <= rd_en;
      if (state == IDLE && start) begin
        num_q  <= num_beats;
        issued <= '0;
      end else if (rd_en) begin
        issued <= issued + LEN_WIDTH'(1);
      end
      if (state == WAIT_MAX && max_valid) max_q <= max_in;
    end
  end

  mode6_sub_skid_fifo #(
    .W(NUM_LANES*DATAWIDTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (reset),
    .push (rd_valid),
    .pop  (pop),
    .din  (sub_z),
    .dout (out_data),
    .count(fifo_count)
  );

`ifdef MODE6_SUB_STATUS_EN
  logic [7:0] lane_or;

  always_comb begin
    lane_or = '0;
    for (int i = 0; i < NUM_LANES; i++) lane_or = lane_or | sub_status[i*8 +: 8];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) row_status <= '0;
    else if (state == IDLE && start) row_status <= '0;
    else if (rd_valid) row_status <= row_status | lane_or;
  end
`endif
endmodule

// File: tb/tb_mode6_sub_ctrl.sv
// Self-checking bench for mode6_sub_ctrl: table rows with timing targets, a mid-row
// reset sequence and randomized rows checked against a beat-level scoreboard.
module tb_mode6_sub_ctrl;
  import mode6_sub_ctrl_pkg::*;

  localparam int DW   = 16;
  localparam int NL   = 8;
  localparam int LW   = 10;
  localparam int BW   = NL * DW;
  localparam int SKIP = -99;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [LW-1:0] num_beats;
  logic [DW-1:0] max_in;
  logic          max_valid;
  logic          rd_en;
  logic [LW-1:0] rd_addr;
  logic [BW-1:0] rd_data = '0;
  logic [BW-1:0] sub_a;
  logic [DW-1:0] sub_b;
  logic [BW-1:0] sub_z;
  logic [BW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic [2:0]    state_dbg;
`ifdef MODE6_SUB_STATUS_EN
  logic [NL*8-1:0] sub_status;
  logic [7:0]      row_status;
  logic            tb_rd_valid;
  logic [LW-1:0]   tb_rd_addr;
`endif

  mode6_sub_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_beats (num_beats),
    .max_in    (max_in),
    .max_valid (max_valid),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .sub_a     (sub_a),
    .sub_b     (sub_b),
    .sub_z     (sub_z),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
`ifdef MODE6_SUB_STATUS_EN
    .sub_status(sub_status),
    .row_status(row_status),
`endif
    .state_dbg (state_dbg)
  );

  // ---------------- clock / environment models ----------------
  always #5 clk = ~clk;

  logic [BW-1:0] buf_mem [0:63];

  always @(posedge clk) if (rd_en) rd_data <= buf_mem[rd_addr[5:0]];

  always_comb begin
    sub_z = '0;
    for (int i = 0; i < NL; i++) sub_z[i*DW +: DW] = sub_a[i*DW +: DW] - sub_b;
  end

`ifdef MODE6_SUB_STATUS_EN
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      tb_rd_valid <= 1'b0;
      tb_rd_addr  <= '0;
    end else begin
      tb_rd_valid <= rd_en;
      tb_rd_addr  <= rd_addr;
    end
  end

  always_comb begin
    sub_status = '0;
    if (tb_rd_valid && tb_rd_addr == LW'(1)) sub_status[5*8 +: 8] = 8'h20;
  end
`endif

  // ---------------- scoreboard ----------------
  logic [BW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [BW-1:0] exp_beat(input logic [BW-1:0] a, input logic [DW-1:0] m);
    logic [BW-1:0] r;
    r = '0;
    for (int i = 0; i < NL; i++) r[i*DW +: DW] = a[i*DW +: DW] - m;
    return r;
  endfunction

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- row driver + monitor ----------------
  // rmode: 0 ready high, 1 ready low for cycles lo..hi, 2 random ready and spurious starts.
  task automatic run_row(input int n, input int md, input int rmode, input int lo, input int hi,
                         input int e_done, input int e_rd, input int e_ov);
    logic [DW-1:0] mmax;
    logic [BW-1:0] hold_data;
    bit hold_pend;
    int latch_cyc, exp_addr, issued, popped, first_rd, first_ov, done_cyc, budget;
    mmax = '0; hold_data = '0; hold_pend = 0;
    latch_cyc = -1; exp_addr = 0; issued = 0; popped = 0;
    first_rd = -1; first_ov = -1; done_cyc = -1;
    budget = 40 + 8*n + md;
    exp_q.delete();
    for (int k = 0; k < n; k++) buf_mem[k] = {$urandom, $urandom, $urandom, $urandom};

    for (int cyc = 0; cyc < budget; cyc++) begin
      @(posedge clk); #1;
      start     = (cyc == 0) || (rmode == 2 && done_cyc < 0 && $urandom_range(0, 7) == 0);
      num_beats = (cyc == 0) ? LW'(n) : LW'($urandom_range(0, 15));
      max_valid = (cyc >= md);
      max_in    = DW'($urandom);
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = !(cyc >= lo && cyc <= hi);
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (latch_cyc < 0 && cyc >= 1 && cyc >= md) begin
        latch_cyc = cyc;
        mmax = max_in;
        for (int k = 0; k < n; k++) exp_q.push_back(exp_beat(buf_mem[k], mmax));
      end

      @(negedge clk);
      if (cyc == 0) chk("busy_idle_c0", BW'(busy), BW'(0));
      if (cyc == 1) begin
        chk("busy_c1", BW'(busy), BW'(1));
`ifdef MODE6_SUB_STATUS_EN
        chk("status_cleared", BW'(row_status), BW'(0));
`endif
      end
      if (latch_cyc >= 0 && cyc > latch_cyc && done_cyc < 0) chk("sub_b_held", BW'(sub_b), BW'(mmax));
      if (hold_pend) begin
        chk("hold_valid", BW'(out_valid), BW'(1));
        chk("hold_data", out_data, hold_data);
      end
      if (rd_en) begin
        if (first_rd < 0) first_rd = cyc;
        issued++;
        chk("rd_after_max", BW'(latch_cyc >= 0 && cyc > latch_cyc), BW'(1));
        chk("rd_addr", BW'(rd_addr), BW'(exp_addr));
        chk("rd_count", BW'(issued <= n), BW'(1));
        exp_addr++;
      end
      if (out_valid && first_ov < 0) first_ov = cyc;
      if (out_valid && out_ready) begin
        popped++;
        if (exp_q.size() == 0) chk("extra_beat", BW'(popped), BW'(n));
        else chk("beat_data", out_data, exp_q.pop_front());
      end
      if (rd_en) chk("occupancy_le_2", BW'((issued - popped) <= 2), BW'(1));
      hold_pend = out_valid && !out_ready;
      hold_data = out_data;
      if (done) begin
        if (done_cyc >= 0) chk("done_single_pulse", BW'(cyc), BW'(done_cyc));
        else done_cyc = cyc;
        chk("done_all_accepted", BW'(popped), BW'(n));
`ifdef MODE6_SUB_STATUS_EN
        chk("row_status", BW'(row_status), (n >= 2) ? BW'(8'h20) : BW'(0));
`endif
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        chk("idle_after_done", BW'(busy), BW'(0));
        break;
      end
    end

    start = 1'b0;
    if (done_cyc < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL row_timeout: no done within %0d cycles, required done (n=%0d)", budget, n);
    end
    chk("beats_delivered", BW'(popped), BW'(n));
    if (e_done != SKIP) chk("done_cycle", BW'(done_cyc), BW'(e_done));
    if (e_rd != SKIP)   chk("first_rd_cycle", BW'(first_rd), BW'(e_rd));
    if (e_ov != SKIP)   chk("first_ov_cycle", BW'(first_ov), BW'(e_ov));
  endtask

  typedef struct {
    int n, md, rmode, lo, hi, e_done, e_rd, e_ov;
  } vec_t;
  vec_t tbl [8];

  // ---------------- main sequence ----------------
  initial begin
    tbl[0] = '{4, 0, 0, 0, 0,  8,  2,  4};  // basic row
    tbl[1] = '{3, 5, 0, 0, 0, 11,  6,  8};  // max arrives late
    tbl[2] = '{0, 0, 0, 0, 0,  2, -1, -1};  // zero length
    tbl[3] = '{0, 3, 0, 0, 0,  4, -1, -1};  // zero length, late max
    tbl[4] = '{6, 0, 1, 5, 10, 16,  2,  4}; // backpressure stall
    tbl[5] = '{1, 0, 0, 0, 0,  5,  2,  4};
    tbl[6] = '{5, 2, 0, 0, 0, 10,  3,  5};
    tbl[7] = '{8, 1, 0, 0, 0, 12,  2,  4};

    reset = 1'b1; start = 1'b0; num_beats = '0; max_in = '0; max_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_en", BW'(rd_en), BW'(0));
    chk("rst_rd_addr", BW'(rd_addr), BW'(0));
    chk("rst_out_valid", BW'(out_valid), BW'(0));
    chk("rst_busy", BW'(busy), BW'(0));
    chk("rst_done", BW'(done), BW'(0));
    chk("rst_sub_b", BW'(sub_b), BW'(0));
    chk("rst_out_data", out_data, BW'(0));
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++)
      run_row(tbl[i].n, tbl[i].md, tbl[i].rmode, tbl[i].lo, tbl[i].hi,
              tbl[i].e_done, tbl[i].e_rd, tbl[i].e_ov);

    // Reset in the cycle after the second beat is captured.
    for (int k = 0; k < 5; k++) buf_mem[k] = {$urandom, $urandom, $urandom, $urandom};
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(posedge clk); #1;
      start = (cyc == 0); num_beats = LW'(5); max_valid = 1'b1; out_ready = 1'b1;
    end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("midrst_rd_en", BW'(rd_en), BW'(0));
    chk("midrst_rd_addr", BW'(rd_addr), BW'(0));
    chk("midrst_out_valid", BW'(out_valid), BW'(0));
    chk("midrst_busy", BW'(busy), BW'(0));
    chk("midrst_done", BW'(done), BW'(0));
    chk("midrst_sub_b", BW'(sub_b), BW'(0));
    chk("midrst_out_data", out_data, BW'(0));
    @(negedge clk);
    reset = 1'b0;
    run_row(3, 0, 0, 0, 0, 7, 2, 4);

    for (int r = 0; r < 8; r++)
      run_row($urandom_range(0, 12), $urandom_range(0, 4), 2, 0, 0, SKIP, SKIP, SKIP);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
